// File: rtl/mux2_arb_pkg.sv
// Shared types and constants for the two-requester mux arbiter.
package mux2_arb_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } st_t;

  // Reset value of the last-granted index, so requester 0 wins the first tie.
  localparam logic LAST_RST = 1'b1;

endpackage

// File: rtl/mux2_w.sv
// WIDTH-wide combinational 2:1 mux; S = 0 selects w0, S = 1 selects w1.
module mux2_w #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] w0,
  input  logic [WIDTH-1:0] w1,
  input  logic             S,
  output logic [WIDTH-1:0] f
);

  assign f = S ? w1 : w0;

endmodule

// File: rtl/mux2_rr_arb.sv
// Two-requester arbiter driving a shared 2:1 mux into a valid/ready holding register.
// Define MUX2_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module mux2_rr_arb
  import mux2_arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] w0,
  input  logic [WIDTH-1:0] w1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             S,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src
);

  st_t             st;
  st_t             st_nxt;
  logic            load;
  logic            winner;
  logic            s_q;
  logic [WIDTH-1:0] mux_f;
`ifndef MUX2_ARB_FIXED_PRIO_EN
  logic            last;
`endif

  mux2_w #(.WIDTH(WIDTH)) u_mux (
    .w0 (w0),
    .w1 (w1),
    .S  (S),
    .f  (mux_f)
  );

  assign out_valid = (st == FULL);

  // Select holds its registered value unless a word is being captured, so it never toggles when idle.
  always_comb begin
    st_nxt = st;
    load   = 1'b0;
    winner = 1'b0;
    S      = s_q;
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    if (rst) begin
      S = 1'b0;
    end else begin
      load = (req0 | req1) & ((st == EMPTY) | out_ready);
`ifdef MUX2_ARB_FIXED_PRIO_EN
      winner = ~req0;
`else
      winner = (req0 & req1) ? ~last : req1;
`endif
      if (load) begin
        S      = winner;
        gnt0   = ~winner;
        gnt1   = winner;
        st_nxt = FULL;
      end else if ((st == FULL) && out_ready) begin
        st_nxt = EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= EMPTY;
      out_data <= '0;
      out_src  <= 1'b0;
      s_q      <= 1'b0;
`ifndef MUX2_ARB_FIXED_PRIO_EN
      last     <= LAST_RST;
`endif
    end else begin
      st <= st_nxt;
      if (load) begin
        out_data <= mux_f;
        out_src  <= S;
        s_q      <= S;
`ifndef MUX2_ARB_FIXED_PRIO_EN
        last     <= S;
`endif
      end
    end
  end

endmodule
